pixel_write_mux: RTL and testbench
==================================

// Module: pixel_write_mux
// PURPOSE
//  - Parametrised successor to the single-source pixel path into vga_adapter.
//  - Merges N_CLIENTS independent pixel-drawing clients into one x/y/colour/plot write
//    port; each client has its own pixel FIFO with a valid/ready handshake.
//  - Round-robin arbitration, one pixel per cycle, plus a built-in full-screen clear
//    sequencer. Sits between the game logic (board, notes, HUD) and vga_adapter.
// PARAMETERS
//  N_CLIENTS   3     number of drawing clients (1..8)
//  FIFO_DEPTH  4     entries per client FIFO; power of two, >=2
//  X_W         8     x coordinate width
//  Y_W         7     y coordinate width
//  COLOUR_W    9     colour width (3 bits per channel)
//  H_RES       160   visible columns; used by clear and clip
//  V_RES       120   visible rows; used by clear and clip
// PORTS
//  clk           in   1                   system clock (50 MHz)
//  reset         in   1                   asynchronous, active-high reset
//  req_valid     in   N_CLIENTS           client i has a pixel on its lane
//  req_ready     out  N_CLIENTS           client i FIFO not full
//  req_x         in   N_CLIENTS*X_W       packed x; lane i = [i*X_W +: X_W]
//  req_y         in   N_CLIENTS*Y_W       packed y
//  req_colour    in   N_CLIENTS*COLOUR_W  packed colour
//  clear_start   in   1                   pulse: start full-screen clear
//  clear_colour  in   COLOUR_W            fill colour, sampled on accepted clear_start
//  busy          out  1                   clear sequence in progress
//  x_out         out  X_W                 to vga_adapter x
//  y_out         out  Y_W                 to vga_adapter y
//  colour_out    out  COLOUR_W            to vga_adapter colour
//  plot_out      out  1                   one-cycle write strobe
// BEHAVIOUR
//  - Reset: all outputs 0 (busy=0, plot_out=0, req_ready=all 1s after reset is
//    released), FIFOs empty, RR pointer=N_CLIENTS-1 (client 0 wins first), state IDLE.
//  - Push: on a rising edge with req_valid[i]&&req_ready[i], lane i is written to
//    FIFO i. req_ready[i]=!full[i]; it is combinational from the count and has no
//    dependence on req_valid. A push and a pop on the same FIFO in the same cycle are
//    legal. A FIFO that is full cannot push, so there is no push+pop when full.
//  - Arbitration (DRAIN): each cycle, grant the first non-empty FIFO strictly after
//    the RR pointer, wrapping modulo N_CLIENTS. Pop that FIFO. Register its entry onto
//    x/y/colour_out with plot_out=1. Pointer:=granted index.
//  - If no FIFO is non-empty: plot_out=0 and x/y/colour_out hold their last value.
//  - Latency: a pixel accepted at edge t into an otherwise empty mux has plot_out=1
//    in the cycle after edge t+1.
//  - Per-client order is preserved. Throughput is 1 pixel/cycle aggregate.
//  - FSM states: IDLE/DRAIN (same datapath) and CLEAR.
//    - clear_start in IDLE: enter CLEAR and latch clear_colour. x,y counters start
//      at 0.
//    - In CLEAR: plot_out=1 and colour_out=latched colour every cycle, row-major:
//      x increments and wraps at H_RES-1 to 0 with y+1.
//    - After (H_RES-1,V_RES-1) is emitted, return to IDLE; busy falls on that same
//      edge.
//    - Exactly H_RES*V_RES plot cycles.
//    - busy=1 throughout CLEAR. clear_start while busy is ignored.
//    - In CLEAR, FIFOs still accept pushes until full but are not drained; the RR
//      pointer is frozen.
//    - Clear and drain are never mixed in one cycle. clear_start wins over pending
//      FIFO pixels on the edge it is seen.
//  - Reset mid-operation: immediate return to reset state. The clear is abandoned,
//    FIFO contents are discarded, and plot_out drops asynchronously.
//  - Width rules: the counters are X_W/Y_W wide. H_RES<=2**X_W and V_RES<=2**Y_W;
//    this is checked at elaboration.
// CONFIGURATION
//  - Macro PIXEL_CLIP_EN.
//  - Defined: a popped pixel with x>=H_RES or y>=V_RES is discarded, gives
//    plot_out=0 that cycle, and increments an extra output clip_count
//    [15:0] (saturating at 16'hFFFF, reset 0). The grant and pointer still advance.
//  - Not defined: no bounds check; every popped pixel is plotted as-is, and the
//    clip_count port does not exist.
// STRUCTURE
//  - Package bh_vga_pkg: H_RES/V_RES/COLOUR_W defaults, colour constants
//    (BLACK=9'h000, FAT=9'b011000000, MUSCLE=9'b111000000), FSM state encoding.
//  - Sub-module pwm_fifo: synchronous FIFO, width X_W+Y_W+COLOUR_W, depth FIFO_DEPTH,
//    ports push/pop/din/dout/full/empty. It is instantiated N_CLIENTS times in a
//    generate loop.
//  - The arbiter, clear sequencer and output register are in the top.
// TESTING
//  - Single pixel: client 0 pushes (5,7,9'h1C0) at edge t -> plot_out=1 at t+2 with
//    x=5, y=7, colour=9'h1C0; the next cycle plot_out=0.
//  - Round robin: clients 0,1,2 each push 2 pixels in the same cycle -> output order
//    0,1,2,0,1,2 with no gap cycles.
//  - Backpressure: client 1 pushes 5 pixels with no drain (hold CLEAR) ->
//    req_ready[1]=0 after 4 pushes. The 5th is held and is accepted once draining
//    resumes.
//  - Clear: clear_start with colour 9'h000 -> busy=1 and exactly 19200 plot cycles:
//    the first is (0,0), the 160th is (159,0), the last is (159,119). busy=0 next cycle.
//  - Clear during traffic: pixels queued before clear_start appear only after busy
//    falls, in order. A second clear_start mid-clear has no effect.
//  - Reset at the 100th clear pixel -> busy=0, plot_out=0 immediately; all FIFOs
//    empty. PIXEL_CLIP_EN build: push (200,10) -> no plot, clip_count=1.

Source files
------------

// File: rtl/bh_vga_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bh_vga_pkg
// Description : Shared VGA-path definitions: default raster geometry, colour
//               constants and the pixel_write_mux FSM state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package bh_vga_pkg;

  localparam int H_RES_DEFAULT    = 160;
  localparam int V_RES_DEFAULT    = 120;
  localparam int COLOUR_W_DEFAULT = 9;

  // 3 bits per channel, {R,G,B}
  localparam logic [8:0] BLACK  = 9'h000;
  localparam logic [8:0] FAT    = 9'b011000000;
  localparam logic [8:0] MUSCLE = 9'b111000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } mux_state_t;

  // Index reached k steps after ptr on a ring of n entries.
  function automatic int rr_next(input int ptr, input int k, input int n);
    return (ptr + k) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pwm_fifo
// Description : Synchronous first-word-fall-through FIFO holding one client's
//               queued pixels. dout always shows the oldest entry.
// Revision    : 1.0  initial release
// ============================================================================
module pwm_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/pixel_write_mux.sv
`default_nettype none
// ============================================================================
// Module      : pixel_write_mux
// Description : Merges N_CLIENTS pixel streams (one FIFO each) into a single
//               vga_adapter write port with round-robin arbitration, and
//               provides a full-screen clear sequencer.
//               Optional build macro PIXEL_CLIP_EN: drop off-screen pixels and
//               count them on clip_count.
// Revision    : 1.0  initial release
// ============================================================================
module pixel_write_mux
  import bh_vga_pkg::*;
#(
  parameter int N_CLIENTS  = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COLOUR_W   = COLOUR_W_DEFAULT,
  parameter int H_RES      = H_RES_DEFAULT,
  parameter int V_RES      = V_RES_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_CLIENTS-1:0]            req_valid,
  output logic [N_CLIENTS-1:0]            req_ready,
  input  logic [N_CLIENTS*X_W-1:0]        req_x,
  input  logic [N_CLIENTS*Y_W-1:0]        req_y,
  input  logic [N_CLIENTS*COLOUR_W-1:0]   req_colour,
  input  logic                            clear_start,
  input  logic [COLOUR_W-1:0]             clear_colour,
  output logic                            busy,
  output logic [X_W-1:0]                  x_out,
  output logic [Y_W-1:0]                  y_out,
  output logic [COLOUR_W-1:0]             colour_out,
  output logic                            plot_out
`ifdef PIXEL_CLIP_EN
  ,
  output logic [15:0]                     clip_count
`endif
);

  localparam int ENTRY_W = X_W + Y_W + COLOUR_W;
  localparam int IDX_W   = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  // Elaboration-time parameter sanity.
  generate
    if (H_RES < 1 || V_RES < 1 || H_RES > (1 << X_W) || V_RES > (1 << Y_W)) begin : g_bad_res
      $error("pixel_write_mux: H_RES/V_RES do not fit the X_W/Y_W counters");
    end
    if (N_CLIENTS < 1 || N_CLIENTS > 8) begin : g_bad_clients
      $error("pixel_write_mux: N_CLIENTS must be 1..8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pixel_write_mux: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  mux_state_t             state;
  mux_state_t             state_next;

  logic [ENTRY_W-1:0]     fifo_dout [N_CLIENTS];
  logic [N_CLIENTS-1:0]   fifo_full;
  logic [N_CLIENTS-1:0]   fifo_empty;
  logic [N_CLIENTS-1:0]   fifo_push;
  logic [N_CLIENTS-1:0]   fifo_pop;

  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_valid;
  logic                   drain_en;
  logic [ENTRY_W-1:0]     sel_entry;
  logic [X_W-1:0]         sel_x;
  logic [Y_W-1:0]         sel_y;
  logic [COLOUR_W-1:0]    sel_colour;
  logic                   sel_clip;

  logic [X_W-1:0]         x_reg;
  logic [Y_W-1:0]         y_reg;
  logic [COLOUR_W-1:0]    colour_reg;
  logic                   plot_reg;

  logic [X_W-1:0]         clr_x;
  logic [Y_W-1:0]         clr_y;
  logic [COLOUR_W-1:0]    clr_colour;
  logic                   clr_row_end;
  logic                   clr_last;

  // One FIFO per client; lane i is packed {x, y, colour}.
  generate
    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_fifo
      assign req_ready[i] = !fifo_full[i];
      assign fifo_push[i] = req_valid[i] && !fifo_full[i];

      pwm_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push[i]),
        .pop   (fifo_pop[i]),
        .din   ({req_x[i*X_W +: X_W], req_y[i*Y_W +: Y_W], req_colour[i*COLOUR_W +: COLOUR_W]}),
        .dout  (fifo_dout[i]),
        .full  (fifo_full[i]),
        .empty (fifo_empty[i])
      );
    end
  endgenerate

  // Clear sweeps are never mixed with draining; clear_start pre-empts the drain.
  assign drain_en    = (state != ST_CLEAR) && !clear_start;
  assign clr_row_end = (clr_x == X_W'(H_RES - 1));
  assign clr_last    = clr_row_end && (clr_y == Y_W'(V_RES - 1));

  // Round-robin grant: first non-empty FIFO strictly after rr_ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    for (int k = 1; k <= N_CLIENTS; k++) begin
      if (!grant_valid && !fifo_empty[rr_next(int'(rr_ptr), k, N_CLIENTS)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(rr_next(int'(rr_ptr), k, N_CLIENTS));
      end
    end
  end

  // Pop strobes and head-of-line selection for the granted client.
  always_comb begin
    fifo_pop  = '0;
    sel_entry = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        fifo_pop[i] = drain_en && grant_valid;
        sel_entry   = fifo_dout[i];
      end
    end
  end

  assign sel_x      = sel_entry[ENTRY_W-1 -: X_W];
  assign sel_y      = sel_entry[COLOUR_W +: Y_W];
  assign sel_colour = sel_entry[COLOUR_W-1:0];

`ifdef PIXEL_CLIP_EN
  assign sel_clip = ({1'b0, sel_x} >= (X_W + 1)'(H_RES)) ||
                    ({1'b0, sel_y} >= (Y_W + 1)'(V_RES));

  // Saturating count of drained pixels that fell outside the visible area.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip_count <= '0;
    end else if (drain_en && grant_valid && sel_clip && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`else
  assign sel_clip = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // FSM next-state: clear wins over pending pixels; clear ends on its last pixel.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DRAIN: begin
        if (clear_start)      state_next = ST_CLEAR;
        else if (grant_valid) state_next = ST_DRAIN;
        else                  state_next = ST_IDLE;
      end
      ST_CLEAR: begin
        if (clr_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: during a clear the sweep counters drive the port directly.
  always_comb begin
    busy       = (state == ST_CLEAR);
    plot_out   = busy ? 1'b1       : plot_reg;
    x_out      = busy ? clr_x      : x_reg;
    y_out      = busy ? clr_y      : y_reg;
    colour_out = busy ? clr_colour : colour_reg;
  end

  // Datapath: drain output register, RR pointer and clear sweep counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= IDX_W'(N_CLIENTS - 1);
      x_reg      <= '0;
      y_reg      <= '0;
      colour_reg <= '0;
      plot_reg   <= 1'b0;
      clr_x      <= '0;
      clr_y      <= '0;
      clr_colour <= '0;
    end else if (state == ST_CLEAR) begin
      // Track the sweep so the port holds the final clear pixel afterwards.
      x_reg      <= clr_x;
      y_reg      <= clr_y;
      colour_reg <= clr_colour;
      plot_reg   <= 1'b0;
      if (clr_row_end) begin
        clr_x <= '0;
        clr_y <= clr_last ? '0 : clr_y + 1'b1;
      end else begin
        clr_x <= clr_x + 1'b1;
      end
    end else if (clear_start) begin
      clr_colour <= clear_colour;
      clr_x      <= '0;
      clr_y      <= '0;
      plot_reg   <= 1'b0;
    end else if (grant_valid) begin
      rr_ptr   <= grant_idx;
      plot_reg <= !sel_clip;
      if (!sel_clip) begin
        x_reg      <= sel_x;
        y_reg      <= sel_y;
        colour_reg <= sel_colour;
      end
    end else begin
      plot_reg <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_write_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_write_mux
// Description : Self-checking bench for pixel_write_mux: queue-based reference
//               model feeding a scoreboard, independent output monitor.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pixel_write_mux;
  import bh_vga_pkg::*;

  localparam int N     = 3;
  localparam int DEPTH = 4;
  localparam int XW    = 8;
  localparam int YW    = 7;
  localparam int CW    = 9;
  localparam int HR    = 160;
  localparam int VR    = 120;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
  } pix_t;

  typedef struct {
    int   cyc;
    pix_t p;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*XW-1:0]   req_x = '0;
  logic [N*YW-1:0]   req_y = '0;
  logic [N*CW-1:0]   req_colour = '0;
  logic              clear_start = 1'b0;
  logic [CW-1:0]     clear_colour = '0;
  logic              busy;
  logic [XW-1:0]     x_out;
  logic [YW-1:0]     y_out;
  logic [CW-1:0]     colour_out;
  logic              plot_out;
`ifdef PIXEL_CLIP_EN
  logic [15:0]       clip_count;
`endif

  pixel_write_mux dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_colour   (req_colour),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .busy         (busy),
    .x_out        (x_out),
    .y_out        (y_out),
    .colour_out   (colour_out),
    .plot_out     (plot_out)
`ifdef PIXEL_CLIP_EN
    ,
    .clip_count   (clip_count)
`endif
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int clr_plots = 0;

  // Reference model state
  pix_t mq [N][$];
  pix_t src[N][$];
  exp_t sb[$];
  int   m_ptr;
  bit   m_clear;
  int   m_idx;
  logic [CW-1:0] m_cc;
  int   m_clip;

  logic [N-1:0] drv_valid;
  pix_t         drv_pix[N];
  bit           acc[N];
  int           gate_pct = 100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit off_screen(input pix_t p);
`ifdef PIXEL_CLIP_EN
    return (int'(p.x) >= HR) || (int'(p.y) >= VR);
`else
    return 1'b0;
`endif
  endfunction

  function automatic pix_t rand_pix();
    pix_t p;
    p.x = XW'($urandom_range(255));
    p.y = YW'($urandom_range(127));
    p.c = CW'($urandom);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      src[i].delete();
    end
    sb.delete();
    m_ptr   = N - 1;
    m_clear = 1'b0;
    m_idx   = 0;
    m_cc    = '0;
    m_clip  = 0;
  endtask

  task automatic push_clear_pix();
    pix_t p;
    p.x = XW'(m_idx % HR);
    p.y = YW'(m_idx / HR);
    p.c = m_cc;
    sb.push_back('{edge_cnt + 1, p});
  endtask

  // Advances the model across the coming clock edge using the driven inputs.
  task automatic model_edge();
    for (int i = 0; i < N; i++) acc[i] = drv_valid[i] && (mq[i].size() < DEPTH);
    if (m_clear) begin
      m_idx++;
      if (m_idx == HR * VR) m_clear = 1'b0;
      else push_clear_pix();
    end else if (clear_start) begin
      m_clear = 1'b1;
      m_idx   = 0;
      m_cc    = clear_colour;
      push_clear_pix();
    end else begin
      for (int k = 1; k <= N; k++) begin
        int   c;
        pix_t p;
        c = (m_ptr + k) % N;
        if (mq[c].size() > 0) begin
          p = mq[c].pop_front();
          m_ptr = c;
          if (off_screen(p)) m_clip++;
          else sb.push_back('{edge_cnt + 1, p});
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(drv_pix[i]);
  endtask

  task automatic step(input bit cs, input logic [CW-1:0] ccol);
    for (int i = 0; i < N; i++) begin
      drv_pix[i]   = '0;
      drv_valid[i] = 1'b0;
      if (src[i].size() > 0) begin
        drv_pix[i]   = src[i][0];
        drv_valid[i] = ($urandom_range(99) < gate_pct);
      end
      req_x[i*XW +: XW]      = drv_pix[i].x;
      req_y[i*YW +: YW]      = drv_pix[i].y;
      req_colour[i*CW +: CW] = drv_pix[i].c;
    end
    req_valid    = drv_valid;
    clear_start  = cs;
    clear_colour = ccol;
    for (int i = 0; i < N; i++) chk("req_ready", req_ready[i], mq[i].size() < DEPTH);
    model_edge();
    @(posedge clk);
    #1;
    chk("busy", busy, m_clear);
    for (int i = 0; i < N; i++) if (acc[i]) void'(src[i].pop_front());
    clear_start = 1'b0;
    req_valid   = '0;
  endtask

  task automatic run_drain(input int budget);
    int  n;
    bit  pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < budget) begin
      pending = m_clear || (sb.size() > 0);
      for (int i = 0; i < N; i++) if (src[i].size() > 0 || mq[i].size() > 0) pending = 1'b1;
      if (pending) begin
        step(1'b0, '0);
        n++;
      end
    end
    chk("drain_within_budget", pending, 1'b0);
  endtask

  // Monitor: every plot cycle must match the oldest expected pixel and cycle.
  always @(negedge clk) begin
    if (!reset) begin
      while (sb.size() > 0 && sb[0].cyc < edge_cnt) begin
        chk("plot_missing_at_cycle", edge_cnt, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (plot_out === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_plot", plot_out, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("plot_cycle", edge_cnt, e.cyc);
          chk("plot_pixel", {x_out, y_out, colour_out}, e.p);
          if (busy) clr_plots++;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_plot", plot_out, 1'b0);
    chk("reset_xyc", {x_out, y_out, colour_out}, 0);
    chk("reset_ready", req_ready, {N{1'b1}});

    // Single pixel
    src[0].push_back({8'd5, 7'd7, 9'h1C0});
    run_drain(50);

    // Round robin: two pixels per client, all lanes together
    for (int i = 0; i < N; i++) begin
      src[i].push_back(rand_pix());
      src[i].push_back(rand_pix());
    end
    run_drain(50);

    // Clear during traffic, backpressure and an ignored second clear_start
    src[2].push_back(rand_pix());
    src[2].push_back(rand_pix());
    step(1'b0, '0);
    clr_plots = 0;
    step(1'b1, BLACK);
    for (int j = 0; j < 5; j++) src[1].push_back(rand_pix());
    n = 0;
    while (m_clear && n < HR * VR + 10) begin
      step(n == 200, MUSCLE);
      n++;
    end
    chk("clear_plot_count", clr_plots, HR * VR);
    run_drain(100);

    // Randomized traffic
    gate_pct = 60;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (src[i].size() < 3 && $urandom_range(1) == 1) src[i].push_back(rand_pix());
      step(1'b0, '0);
    end
    gate_pct = 100;
    run_drain(200);

    // Reset at the 100th clear pixel with pixels still queued
    for (int j = 0; j < 3; j++) src[0].push_back(rand_pix());
    step(1'b1, FAT);
    repeat (99) step(1'b0, '0);
    #2;
    chk("plot_before_reset", plot_out, 1'b1);
    chk("x_before_reset", x_out, 99);
    reset = 1'b1;
    model_reset();
    #1;
    chk("reset_async_plot", plot_out, 1'b0);
    chk("reset_async_busy", busy, 1'b0);
    chk("reset_async_ready", req_ready, {N{1'b1}});
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("post_reset_ready", req_ready, {N{1'b1}});
    src[1].push_back(rand_pix());
    run_drain(50);

`ifdef PIXEL_CLIP_EN
    chk("clip_count_after_reset", clip_count, 0);
    src[0].push_back({8'd200, 7'd10, 9'h1FF});
    run_drain(50);
    chk("clip_count", clip_count, m_clip);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
